// File: rtl/pipe_skid_32_pkg.sv
// rtl/pipe_skid_32_pkg.sv - shared state encoding and width constants for pipe_skid_32
package pipe_skid_32_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int STAT_W         = 16;

endpackage

// File: rtl/pipe_skid_32_ctrl.sv
// rtl/pipe_skid_32_ctrl.sv - skid buffer FSM with registered in_ready/out_valid and data load enables
module pipe_skid_ctrl
    import pipe_skid_32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic main_load,
    output logic skid_load,
    output logic main_sel_skid
);

    state_t state;
    state_t state_nxt;
    logic   in_acc;
    logic   out_acc;

    always_comb begin
        in_acc        = in_valid & in_ready;
        out_acc       = out_valid & out_ready;
        state_nxt     = state;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_acc) begin
                    main_load = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_acc && out_acc) begin
                    main_load = 1'b1;
                end else if (in_acc) begin
                    skid_load = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_acc) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_acc) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    state_nxt     = ST_BUSY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs are re-registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

endmodule

// File: rtl/pipe_skid_32.sv
// rtl/pipe_skid_32.sv - valid/ready stage with two-entry skid buffer; PIPE_SKID_STATS_EN adds stat_beats
module pipe_skid_32
    import pipe_skid_32_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_beats
`endif
);

    logic             main_load;
    logic             skid_load;
    logic             main_sel_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_skid_ctrl u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .main_load     (main_load),
        .skid_load     (skid_load),
        .main_sel_skid (main_sel_skid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load) begin
                main_q <= main_sel_skid ? skid_q : in_data;
            end
            if (skid_load) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = main_q;

`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats <= '0;
        end else if (out_valid && out_ready) begin
            stat_beats <= stat_beats + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_32.sv
// tb/tb_pipe_skid_32.sv - table vectors plus queue scoreboard for pipe_skid_32
module tb_pipe_skid_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stat_beats;
`endif

    pipe_skid_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    logic [31:0] last_out;
    logic [15:0] m_stat;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference queue model on the edge, then check outputs.
    task automatic step(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
        logic acc_in;
        logic acc_out;
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        acc_in  = iv && (sb.size() < 2);
        acc_out = ordy && (sb.size() > 0);
        @(posedge clk);
        if (r) begin
            sb.delete();
            last_out = '0;
            m_stat   = '0;
        end else begin
            if (acc_out) begin
                last_out = sb.pop_front();
                m_stat   = m_stat + 16'd1;
            end
            if (acc_in) sb.push_back(d);
        end
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        chk("out_data", out_data, (sb.size() > 0) ? sb[0] : last_out);
`ifdef PIPE_SKID_STATS_EN
        chk("stat_beats", {16'd0, stat_beats}, {16'd0, m_stat});
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [31:0] e_od);
        vec_t v;
        v.r = r; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
        return v;
    endfunction

    initial begin
        last_out = '0;
        m_stat   = '0;
        // reset with a beat presented
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 1, 0, 32'h0));
        // streaming
        tbl.push_back(mk(0, 1, 32'h1, 1, 1, 1, 32'h1));
        tbl.push_back(mk(0, 1, 32'h2, 1, 1, 1, 32'h2));
        tbl.push_back(mk(0, 1, 32'h3, 1, 1, 1, 32'h3));
        tbl.push_back(mk(0, 1, 32'h4, 1, 1, 1, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h4));
        // backpressure, 0xC refused while full
        tbl.push_back(mk(0, 1, 32'hA, 0, 1, 1, 32'hA));
        tbl.push_back(mk(0, 1, 32'hB, 0, 0, 1, 32'hA));
        tbl.push_back(mk(0, 1, 32'hC, 0, 0, 1, 32'hA));
        tbl.push_back(mk(0, 1, 32'hC, 1, 1, 1, 32'hB));
        tbl.push_back(mk(0, 1, 32'hC, 1, 1, 1, 32'hC));
        tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'hC));
        // simultaneous accept in BUSY
        tbl.push_back(mk(0, 1, 32'h10, 0, 1, 1, 32'h10));
        tbl.push_back(mk(0, 1, 32'h11, 1, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 32'h0, 0, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h11));
        // reset while full discards both beats
        tbl.push_back(mk(0, 1, 32'h5, 0, 1, 1, 32'h5));
        tbl.push_back(mk(0, 1, 32'h6, 0, 0, 1, 32'h5));
        tbl.push_back(mk(1, 1, 32'h7, 1, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
        end

        // random traffic against the scoreboard, including the occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 2) != 0);
        end

        // stability under stall: hold out_ready low, data must not move
        step(0, 1, 32'h77, 0);
        step(0, 1, 32'h88, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h99, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1);

`ifdef PIPE_SKID_STATS_EN
        step(1, 0, 32'h0, 0);
        chk("stat_reset", {16'd0, stat_beats}, 32'd0);
        for (int i = 0; i < 65538; i++) step(0, 1, i, 1);
        chk("stat_wrap", {16'd0, stat_beats}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
